// File: rtl/mem_byte_sequencer_pkg.sv
// mem_byte_sequencer_pkg: shared sequencer state encoding, word size and op encodings
package mem_byte_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    DONE    = 2'b10,
    CLEANUP = 2'b11
  } state_t;
  localparam int WORD_BYTES = 4;
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic WORD  = 1'b1;
  localparam logic BYTE  = 1'b0;
endpackage

// File: rtl/mem_byte_sequencer_if.sv
// mem_byte_sequencer_if: byte-wide memory bus between the sequencer (master) and memory (slave)
interface mem_byte_sequencer_if;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  modport master (output mem_addr, mem_en, mem_we, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_addr, mem_en, mem_we, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mem_lane_mux.sv
// mem_lane_mux: big-endian 32<->8 lane select, byte k lives in data[31-8k:24-8k]
module mem_lane_mux
  import mem_byte_sequencer_pkg::*;
(
  input  logic [1:0]  k,
  input  logic        word,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [7:0]  rbyte,
  output logic [7:0]  wbyte,
  output logic [31:0] rdata_merged
);
  logic [4:0] sh;
  always_comb begin
    sh = {~k, 3'b000};
    wbyte = (word == WORD) ? wdata[sh +: 8] : wdata[7:0];
    rdata_merged = (word == WORD) ? ((rdata & ~(32'hff << sh)) | ({24'h0, rbyte} << sh)) : {24'h0, rbyte};
  end
endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: turns CPU word/byte requests into a sequence of byte accesses
// on an 8-bit memory, with abort on early MFA release.
module mem_byte_sequencer
  import mem_byte_sequencer_pkg::*;
(
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        MFA,
  input  logic                        READ_WRITE,
  input  logic                        WORD_BYTE,
  input  logic [31:0]                 addr,
  input  logic [31:0]                 wdata,
  output logic                        MFC,
  output logic                        busy,
  output logic [31:0]                 rdata,
  mem_byte_sequencer_if.master        mem
);
  state_t      state;
  logic [1:0]  k;
  logic        op_rw;
  logic        op_word;
  logic        abort;
  logic        last;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [31:0] rdata_merged;
  logic [7:0]  wbyte;
  mem_lane_mux u_lane_mux (
    .k            (k),
    .word         (op_word),
    .wdata        (op_wdata),
    .rdata        (rdata),
    .rbyte        (mem.mem_rdata),
    .wbyte        (wbyte),
    .rdata_merged (rdata_merged)
  );
  // Every output is decoded from registered state, so mem_ready never reaches mem_en.
  assign last          = k == ((op_word == BYTE) ? 2'd0 : 2'(WORD_BYTES - 1));
  assign MFC           = state == DONE;
  assign busy          = state != IDLE;
  assign mem.mem_en    = state == ACCESS;
  assign mem.mem_we    = (state == ACCESS) && (op_rw == WRITE);
  assign mem.mem_addr  = op_addr + {30'd0, k};
  assign mem.mem_wdata = wbyte;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state    <= IDLE;
      k        <= 2'd0;
      op_rw    <= 1'b0;
      op_word  <= 1'b0;
      op_addr  <= '0;
      op_wdata <= '0;
      rdata    <= '0;
      abort    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (MFA) begin
          op_rw    <= READ_WRITE;
          op_word  <= WORD_BYTE;
          op_addr  <= (WORD_BYTE == WORD) ? {addr[31:2], 2'b00} : addr;
          op_wdata <= wdata;
          k        <= 2'd0;
          abort    <= 1'b0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A dropped MFA is remembered so the byte in flight still finishes first.
          abort <= abort | !MFA;
          if (mem.mem_ready) begin
            if (op_rw == READ) rdata <= rdata_merged;
            k     <= last ? k : k + 2'd1;
            state <= (abort || !MFA) ? CLEANUP : last ? DONE : ACCESS;
          end
        end
        DONE: state <= MFA ? DONE : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb_mem_byte_sequencer: directed plus random transfers against a byte-array reference memory.
module tb_mem_byte_sequencer;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MFA = 1'b0;
  logic        READ_WRITE = 1'b0;
  logic        WORD_BYTE = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        MFC;
  logic        busy;
  logic [31:0] rdata;
  mem_byte_sequencer_if bus ();
  mem_byte_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .MFA        (MFA),
    .READ_WRITE (READ_WRITE),
    .WORD_BYTE  (WORD_BYTE),
    .addr       (addr),
    .wdata      (wdata),
    .MFC        (MFC),
    .busy       (busy),
    .rdata      (rdata),
    .mem        (bus)
  );
  logic [7:0]  mem     [0:4095] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:4095] = '{default: 8'h00};
  logic [31:0] q_addr [$];
  logic        q_we   [$];
  logic [7:0]  q_wd   [$];
  int          waits = 0;
  int          wcnt = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata = '0;
  always #5 Clk = ~Clk;
  // Memory device: each byte is accepted after `waits` stall cycles.
  assign bus.mem_ready = bus.mem_en && (wcnt >= waits);
  assign bus.mem_rdata = mem[bus.mem_addr[11:0]];
  always @(posedge Clk) begin
    wcnt <= (bus.mem_en && !bus.mem_ready) ? wcnt + 1 : 0;
    if (bus.mem_en && bus.mem_ready) begin
      if (bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
      q_addr.push_back(bus.mem_addr);
      q_we.push_back(bus.mem_we);
      q_wd.push_back(bus.mem_wdata);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic do_op(input logic rw, input logic word, input logic [31:0] a, input logic [31:0] wd,
                       input int w, input int hold);
    int n, q0, cyc;
    logic [31:0] base, ba, er, t;
    logic [7:0] eb;
    n = word ? 4 : 1;
    base = word ? {a[31:2], 2'b00} : a;
    waits = w;
    q0 = q_addr.size();
    @(negedge Clk);
    MFA = 1'b1; READ_WRITE = rw; WORD_BYTE = word; addr = a; wdata = wd;
    @(posedge Clk); #1;
    chk("busy_start", 32'(busy), 1);
    cyc = 0;
    while (MFC !== 1'b1 && cyc < 200) begin
      @(posedge Clk); #1;
      cyc++;
    end
    chk("mfc_latency", cyc, n * (1 + w));
    er = exp_rdata;
    for (int i = 0; i < n; i++) begin
      ba = base + i;
      t = wd >> (8 * (3 - i));
      eb = word ? t[7:0] : wd[7:0];
      if (rw) er = word ? {er[23:0], ref_mem[ba[11:0]]} : {24'h0, ref_mem[ba[11:0]]};
      else ref_mem[ba[11:0]] = eb;
      if (q_addr.size() > q0 + i) begin
        chk("mem_addr", q_addr[q0 + i], ba);
        chk("mem_we", 32'(q_we[q0 + i]), 32'(!rw));
        if (!rw) chk("mem_wdata", 32'(q_wd[q0 + i]), 32'(eb));
      end
    end
    chk("access_count", q_addr.size() - q0, n);
    chk("rdata", rdata, er);
    exp_rdata = er;
    chk("done_mem_en", 32'(bus.mem_en), 0);
    repeat (hold) begin
      @(posedge Clk); #1;
      chk("hold_mfc", 32'(MFC), 1);
    end
    chk("hold_no_access", q_addr.size() - q0, n);
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk); #1;
    chk("mfc_clear", 32'(MFC), 0);
    chk("busy_clear", 32'(busy), 0);
  endtask
  task automatic do_abort(input logic [31:0] a);
    int q0, cyc;
    logic mfc_seen;
    logic [31:0] base, b1, er;
    base = {a[31:2], 2'b00};
    b1 = base + 1;
    waits = 1;
    q0 = q_addr.size();
    mfc_seen = 1'b0;
    cyc = 0;
    @(negedge Clk);
    MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; addr = a;
    while (q_addr.size() < q0 + 1 && cyc < 50) begin
      @(posedge Clk); #1;
      cyc++;
      mfc_seen |= MFC;
    end
    @(negedge Clk);
    MFA = 1'b0;
    while (q_addr.size() < q0 + 2 && cyc < 50) begin
      @(posedge Clk); #1;
      cyc++;
      mfc_seen |= MFC;
    end
    chk("abort_mem_en", 32'(bus.mem_en), 0);
    chk("abort_busy_cleanup", 32'(busy), 1);
    @(posedge Clk); #1;
    chk("abort_busy_idle", 32'(busy), 0);
    chk("abort_access_count", q_addr.size() - q0, 2);
    if (q_addr.size() >= q0 + 2) chk("abort_byte1_addr", q_addr[q0 + 1], b1);
    chk("abort_mfc", 32'(mfc_seen | MFC), 0);
    er = {ref_mem[base[11:0]], ref_mem[b1[11:0]], exp_rdata[15:0]};
    chk("abort_rdata", rdata, er);
    exp_rdata = er;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a, d;
    #2 Reset = 1'b0;
    #1;
    chk("rst_mfc", 32'(MFC), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", rdata, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("idle_after_release", 32'(busy), 0);
    do_op(1'b0, 1'b1, 32'h0000_0100, 32'h1122_3344, 0, 0);
    do_op(1'b1, 1'b1, 32'h0000_0102, 32'h0, 0, 10);
    chk("word_read_value", rdata, 32'h1122_3344);
    do_op(1'b0, 1'b0, 32'h0000_0205, 32'hDEAD_BEEF, 2, 0);
    do_op(1'b0, 1'b0, 32'h0000_03A1, 32'hABCD_EF80, 0, 0);
    do_op(1'b1, 1'b0, 32'h0000_03A1, 32'h0, 1, 0);
    chk("byte_read_zero_ext", rdata, 32'h0000_0080);
    do_abort(32'h0000_0102);
    waits = 1000;
    @(negedge Clk);
    MFA = 1'b1; READ_WRITE = 1'b1; WORD_BYTE = 1'b1; addr = 32'h0000_0140;
    @(posedge Clk);
    @(posedge Clk); #1;
    chk("pre_reset_mem_en", 32'(bus.mem_en), 1);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_mem_en", 32'(bus.mem_en), 0);
    chk("midrst_mfc", 32'(MFC), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_rdata", rdata, 0);
    exp_rdata = '0;
    @(negedge Clk);
    MFA = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    waits = 0;
    @(posedge Clk); #1;
    chk("post_reset_idle", 32'(busy), 0);
    do_op(1'b1, 1'b1, 32'h0000_0103, 32'h0, 0, 0);
    chk("post_reset_read", rdata, 32'h1122_3344);
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      a[11:6] = '0;
      d = $urandom;
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
